// File: rtl/edge_threshold_stats.sv
// edge_threshold_stats: binarizes a Sobel magnitude stream against a per-frame
// threshold and accumulates per-frame edge statistics.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, threshold  - frame start pulse; threshold sampled when start=1
//   pixel_in/valid_in - magnitude stream from sobel_filter
//   pixel_out/valid_out, row, col - binary edge pixel and its raster position
//   edge_count, max_mag, mag_sum, first_edge_idx - per-frame statistics
//   busy              - high while a frame is running
//   frame_done        - one-cycle pulse after the last pixel is output
module edge_threshold_stats #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned FRAME_W  = 254,
  parameter int unsigned FRAME_H  = 254,
  parameter int unsigned EDGE_VAL = 255,
  localparam int unsigned NPIX  = FRAME_W * FRAME_H,
  localparam int unsigned COL_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
  localparam int unsigned ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1,
  localparam int unsigned CNT_W = $clog2(NPIX + 1),
  localparam int unsigned SUM_W = WIDTH + ((NPIX > 1) ? $clog2(NPIX) : 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] pixel_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] pixel_out,
  output logic             valid_out,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [CNT_W-1:0] edge_count,
  output logic [WIDTH-1:0] max_mag,
  output logic [SUM_W-1:0] mag_sum,
  output logic [CNT_W-1:0] first_edge_idx,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FRAME_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FRAME_H - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] thr_q;
  logic             start_pend_q;   // start seen in DONE, applied in IDLE
  logic [WIDTH-1:0] pend_thr_q;
  logic [COL_W-1:0] nxt_col;        // position of the next incoming beat
  logic [ROW_W-1:0] nxt_row;
  logic [CNT_W-1:0] nxt_idx;

  logic             frame_start_c;
  logic             beat_c;
  logic             edge_c;
  logic [WIDTH-1:0] new_thr_c;

  assign edge_c    = (pixel_in >= thr_q);
  assign new_thr_c = start ? threshold : pend_thr_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle control
  always_comb begin
    state_d       = state_q;
    frame_start_c = 1'b0;
    beat_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || start_pend_q) begin
          state_d       = S_RUN;
          frame_start_c = 1'b1;
        end
      end
      S_RUN: begin
        // A start here aborts the frame and drops this cycle's beat
        if (start) begin
          frame_start_c = 1'b1;
        end else if (valid_in) begin
          beat_c = 1'b1;
          if (nxt_idx == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: output pixel, position, and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q          <= '0;
      start_pend_q   <= 1'b0;
      pend_thr_q     <= '0;
      nxt_col        <= '0;
      nxt_row        <= '0;
      nxt_idx        <= '0;
      pixel_out      <= '0;
      valid_out      <= 1'b0;
      col            <= '0;
      row            <= '0;
      edge_count     <= '0;
      max_mag        <= '0;
      mag_sum        <= '0;
      first_edge_idx <= '1;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      valid_out    <= beat_c;
      pixel_out    <= (beat_c && edge_c) ? WIDTH'(EDGE_VAL) : '0;
      frame_done   <= (state_q == S_DONE);
      busy         <= (state_d == S_RUN);
      start_pend_q <= (state_q == S_DONE) && start;
      if ((state_q == S_DONE) && start) pend_thr_q <= threshold;

      if (frame_start_c) begin
        thr_q          <= new_thr_c;
        nxt_col        <= '0;
        nxt_row        <= '0;
        nxt_idx        <= '0;
        col            <= '0;
        row            <= '0;
        edge_count     <= '0;
        max_mag        <= '0;
        mag_sum        <= '0;
        first_edge_idx <= '1;
      end else if (beat_c) begin
        col     <= nxt_col;
        row     <= nxt_row;
        nxt_idx <= nxt_idx + CNT_W'(1);
        if (nxt_col == LAST_COL) begin
          nxt_col <= '0;
          if (nxt_row != LAST_ROW) nxt_row <= nxt_row + ROW_W'(1);
        end else begin
          nxt_col <= nxt_col + COL_W'(1);
        end
        if (edge_c) begin
          edge_count <= edge_count + CNT_W'(1);
          if (first_edge_idx == '1) first_edge_idx <= nxt_idx;
        end
        if (pixel_in > max_mag) max_mag <= pixel_in;
        mag_sum <= mag_sum + SUM_W'(pixel_in);
      end
    end
  end

endmodule

// File: tb/tb_edge_threshold_stats.sv
// Self-checking bench for edge_threshold_stats on a 4x3 frame.
module tb_edge_threshold_stats;

  localparam int FW   = 4;
  localparam int FH   = 3;
  localparam int NP   = FW * FH;
  localparam int W    = 8;
  localparam int CW   = $clog2(FW);
  localparam int RW   = $clog2(FH);
  localparam int NW   = $clog2(NP + 1);
  localparam int SW   = W + $clog2(NP);
  localparam int SENT = (1 << NW) - 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  threshold;
  logic [W-1:0]  pixel_in;
  logic          valid_in;
  logic [W-1:0]  pixel_out;
  logic          valid_out;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [NW-1:0] edge_count;
  logic [W-1:0]  max_mag;
  logic [SW-1:0] mag_sum;
  logic [NW-1:0] first_edge_idx;
  logic          busy;
  logic          frame_done;

  edge_threshold_stats #(
    .WIDTH(W), .FRAME_W(FW), .FRAME_H(FH), .EDGE_VAL(255)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .pixel_in(pixel_in), .valid_in(valid_in),
    .pixel_out(pixel_out), .valid_out(valid_out), .col(col), .row(row),
    .edge_count(edge_count), .max_mag(max_mag), .mag_sum(mag_sum),
    .first_edge_idx(first_edge_idx), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int pix; int row; int col; } out_t;
  typedef struct { int thr; int kind; int gap; int e_cnt; int e_max; int e_sum; int e_first; } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   fd_cyc = 0;
  int   last_v_cyc = 0;
  out_t oq[$];
  int   cur_mags[NP];
  int   exp_pix[NP];
  int   m_cnt, m_max, m_sum, m_first;
  vec_t tbl[7];

  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (valid_out) begin
      oq.push_back('{int'(pixel_out), int'(row), int'(col)});
      last_v_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < NP; i++) begin
      case (kind)
        0: cur_mags[i] = i * 20;
        1: cur_mags[i] = 0;
        2: cur_mags[i] = 255;
        default: cur_mags[i] = int'($urandom_range(255));
      endcase
    end
  endtask

  // Reference: binarize and reduce the whole frame with plain arithmetic
  task automatic model(input int thr);
    m_cnt = 0; m_max = 0; m_sum = 0; m_first = SENT;
    for (int i = 0; i < NP; i++) begin
      exp_pix[i] = (cur_mags[i] >= thr) ? 255 : 0;
      if (cur_mags[i] >= thr) begin
        m_cnt++;
        if (m_first == SENT) m_first = i;
      end
      if (cur_mags[i] > m_max) m_max = cur_mags[i];
      m_sum += cur_mags[i];
    end
  endtask

  task automatic do_start(input int thr);
    @(posedge clk); #1;
    threshold = W'(thr);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int gmax);
    int g;
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      pixel_in = W'(cur_mags[i]);
      @(posedge clk); #1;
      valid_in = 1'b0;
      if (i < n - 1 && gmax > 0) begin
        g = int'($urandom_range(gmax));
        repeat (g) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic check_frame(input string nm, input int thr, input int fd0,
                             input int e_cnt, input int e_max, input int e_sum, input int e_first);
    int k;
    k = 0;
    while (fd_cnt == fd0 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) begin @(negedge clk); #1; end
    chk({nm, " frame_done_count"}, fd_cnt - fd0, 1);
    chk({nm, " frame_done_lag"}, fd_cyc - last_v_cyc, 1);
    chk({nm, " valid_count"}, oq.size(), NP);
    model(thr);
    for (int i = 0; i < NP && i < oq.size(); i++)
      chk($sformatf("%s pix%0d", nm, i),
          (longint'(oq[i].pix) << 16) | (longint'(oq[i].row) << 8) | longint'(oq[i].col),
          (longint'(exp_pix[i]) << 16) | (longint'(i / FW) << 8) | longint'(i % FW));
    chk({nm, " edge_count"}, edge_count, e_cnt);
    chk({nm, " max_mag"}, max_mag, e_max);
    chk({nm, " mag_sum"}, mag_sum, e_sum);
    chk({nm, " first_edge_idx"}, first_edge_idx, e_first);
    chk({nm, " final_row"}, row, FH - 1);
    chk({nm, " final_col"}, col, FW - 1);
    chk({nm, " busy_idle"}, busy, 0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " valid_out"}, valid_out, 0);
    chk({nm, " pixel_out"}, pixel_out, 0);
    chk({nm, " row"}, row, 0);
    chk({nm, " col"}, col, 0);
    chk({nm, " edge_count"}, edge_count, 0);
    chk({nm, " max_mag"}, max_mag, 0);
    chk({nm, " mag_sum"}, mag_sum, 0);
    chk({nm, " first_edge_idx"}, first_edge_idx, SENT);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " frame_done"}, frame_done, 0);
  endtask

  initial begin
    int fd0;
    int thr;

    // {threshold, pattern, max gap, edges, max, sum, first}
    tbl[0] = '{100, 0, 0,  7, 220, 1320,  5};
    tbl[1] = '{100, 0, 3,  7, 220, 1320,  5};
    tbl[2] = '{  1, 1, 0,  0,   0,    0, 15};
    tbl[3] = '{  0, 0, 2, 12, 220, 1320,  0};
    tbl[4] = '{200, 0, 0,  2, 220, 1320, 10};
    tbl[5] = '{220, 0, 1,  1, 220, 1320, 11};
    tbl[6] = '{255, 2, 0, 12, 255, 3060,  0};

    rst = 1'b1; start = 1'b0; valid_in = 1'b0; threshold = '0; pixel_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Beats without start are ignored
    fill(0);
    send_beats(3, 0);
    @(negedge clk); #1;
    chk("idle_drop valid_count", oq.size(), 0);
    chk("idle_drop edge_count", edge_count, 0);
    chk("idle_drop busy", busy, 0);

    for (int t = 0; t < 7; t++) begin
      fill(tbl[t].kind);
      oq.delete();
      fd0 = fd_cnt;
      do_start(tbl[t].thr);
      send_beats(NP, tbl[t].gap);
      check_frame($sformatf("vec%0d", t), tbl[t].thr, fd0,
                  tbl[t].e_cnt, tbl[t].e_max, tbl[t].e_sum, tbl[t].e_first);
    end

    for (int r = 0; r < 4; r++) begin
      fill(3);
      thr = int'($urandom_range(255));
      model(thr);
      oq.delete();
      fd0 = fd_cnt;
      do_start(thr);
      send_beats(NP, 3);
      check_frame($sformatf("rand%0d", r), thr, fd0, m_cnt, m_max, m_sum, m_first);
    end

    // Abort: restart on the 6th beat with threshold 200
    fill(0);
    oq.delete();
    fd0 = fd_cnt;
    do_start(50);
    send_beats(5, 0);
    threshold = 8'd200; start = 1'b1; valid_in = 1'b1; pixel_in = 8'd100;
    @(posedge clk); #1;
    start = 1'b0; valid_in = 1'b0;
    @(negedge clk); #1;
    chk("abort valid_out", valid_out, 0);
    chk("abort edge_count", edge_count, 0);
    chk("abort max_mag", max_mag, 0);
    chk("abort mag_sum", mag_sum, 0);
    chk("abort first_edge_idx", first_edge_idx, SENT);
    chk("abort busy", busy, 1);
    chk("abort no_frame_done", fd_cnt - fd0, 0);
    oq.delete();
    send_beats(NP, 0);
    check_frame("abort_frame", 200, fd0, 2, 220, 1320, 10);

    // Reset at beat 8 (with start also high: reset wins)
    fill(0);
    do_start(100);
    send_beats(7, 0);
    fd0 = fd_cnt;
    rst = 1'b1; start = 1'b1; threshold = 8'd3; valid_in = 1'b1; pixel_in = 8'd140;
    @(posedge clk); #1;
    start = 1'b0; valid_in = 1'b0;
    @(negedge clk); #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(negedge clk); #1; end
    chk("midrst no_frame_done", fd_cnt - fd0, 0);
    chk("midrst busy_after", busy, 0);

    // Start during DONE: frame_done still pulses, next frame begins
    fill(0);
    oq.delete();
    do_start(100);
    send_beats(NP, 0);
    fd0 = fd_cnt;
    threshold = 8'd0; start = 1'b1; valid_in = 1'b1; pixel_in = 8'd77;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk); #1;
    chk("done_start frame_done", fd_cnt - fd0, 1);
    chk("done_start drop", oq.size(), NP);
    chk("done_start busy", busy, 1);
    chk("done_start edge_count", edge_count, 0);
    chk("done_start first_edge_idx", first_edge_idx, SENT);
    oq.delete();
    fd0 = fd_cnt;
    send_beats(NP, 0);
    check_frame("done_start_frame", 0, fd0, 12, 220, 1320, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
